hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. Observes ID/EX stage state and generates the PC write enable plus the stall, hold and flush controls consumed by the IF/ID and ID/EX pipeline registers. Tracks an in-flight multi-cycle mult/div operation with a busy countdown and keeps free-running stall and flush statistics counters. Sits beside the decode stage; its outputs feed the inter-stage registers and the PC register.

---
 rtl/hazard_ctrl_pkg.sv | 14 +
 rtl/hazard_ctrl_md_busy_counter.sv | 29 ++
 rtl/hazard_ctrl.sv | 60 ++++++
 tb/tb_hazard_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared encodings for the pipeline hazard controller
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_LOADUSE = 2'd1,
    CAUSE_MDWAIT  = 2'd2,
    CAUSE_BRANCH  = 2'd3
  } stall_cause_t;
  typedef enum logic {
    MD_RUN  = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;
  localparam int MD_CNT_W = 6;
endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// md_busy_counter: tracks an in-flight mult/div with a reloadable down-counter
module md_busy_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);
  localparam logic [MD_CNT_W-1:0] LAT = MD_CNT_W'(MD_LATENCY);
  md_state_t state, state_n;
  logic [MD_CNT_W-1:0] cnt, cnt_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= MD_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  // a new issue while busy simply restarts the countdown
  always_comb begin
    cnt_n   = start ? LAT : (state == MD_BUSY ? cnt - 1'b1 : cnt);
    state_n = (start || (state == MD_BUSY && cnt_n != '0)) ? MD_BUSY : MD_RUN;
  end
  assign busy = cnt != '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: PC write enable, IF/ID and ID/EX stall/hold/flush control plus statistics
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             ID_MDUse,
  input  logic             EX_MemRd,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_BranchTaken,
  input  logic             EX_MDStart,
  output logic             PCWrite,
  output logic             IFID_Flush,
  output logic             IFID_Hold,
  output logic             IDEX_Flush,
  output logic             MD_Busy,
  output logic [1:0]       StallCause,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  logic load_use, md_wait, stall, flush_evt;
  stall_cause_t cause;
  md_busy_counter #(.MD_LATENCY(MD_LATENCY)) u_md (
    .clk   (clk),
    .reset (reset),
    .start (EX_MDStart),
    .busy  (MD_Busy)
  );
  // reset forces a full flush with the PC frozen and no cause reported
  always_comb begin
    load_use   = EX_MemRd && EX_Rt != 5'd0 &&
                 ((ID_UsesRs && ID_Rs == EX_Rt) || (ID_UsesRt && ID_Rt == EX_Rt));
    md_wait    = MD_Busy && ID_MDUse;
    cause      = reset ? CAUSE_NONE : EX_BranchTaken ? CAUSE_BRANCH :
                 load_use ? CAUSE_LOADUSE : md_wait ? CAUSE_MDWAIT : CAUSE_NONE;
    stall      = cause == CAUSE_LOADUSE || cause == CAUSE_MDWAIT;
    flush_evt  = !reset && (EX_BranchTaken || (ID_Jump && !stall));
    PCWrite    = !reset && !stall;
    IFID_Flush = reset || flush_evt;
    IFID_Hold  = stall;
    IDEX_Flush = reset || EX_BranchTaken || stall;
    StallCause = cause;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stall) StallCount <= StallCount + 1'b1;
      if (flush_evt) FlushCount <= FlushCount + 1'b1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard priority, mult/div busy timing, reset and counter wrap
module tb_hazard_ctrl;
  logic clk = 0;
  logic reset;
  logic [4:0] ID_Rs, ID_Rt, EX_Rt;
  logic ID_UsesRs, ID_UsesRt, ID_Jump, ID_MDUse, EX_MemRd, EX_BranchTaken, EX_MDStart;
  logic PCWrite, IFID_Flush, IFID_Hold, IDEX_Flush, MD_Busy;
  logic [1:0] StallCause;
  logic [3:0] StallCount, FlushCount;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_Jump(ID_Jump), .ID_MDUse(ID_MDUse), .EX_MemRd(EX_MemRd), .EX_Rt(EX_Rt),
    .EX_BranchTaken(EX_BranchTaken), .EX_MDStart(EX_MDStart),
    .PCWrite(PCWrite), .IFID_Flush(IFID_Flush), .IFID_Hold(IFID_Hold),
    .IDEX_Flush(IDEX_Flush), .MD_Busy(MD_Busy), .StallCause(StallCause),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // expected {PCWrite, IFID_Flush, IFID_Hold, IDEX_Flush, StallCause}
  task automatic ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, PCWrite, IFID_Flush, IFID_Hold, IDEX_Flush, StallCause}, {26'd0, exp});
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    {ID_Rs, ID_Rt, EX_Rt} = '0;
    {ID_UsesRs, ID_UsesRt, ID_Jump, ID_MDUse, EX_MemRd, EX_BranchTaken, EX_MDStart} = '0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    EX_MDStart = 1;
    step();
    ctl("reset_ctl", 6'b0_1_0_1_00);
    chk("reset_busy", MD_Busy, 0);
    chk("reset_stallcnt", StallCount, 0);
    chk("reset_flushcnt", FlushCount, 0);
    @(negedge clk);
    reset = 0;
    EX_MDStart = 0;
    #1;
    ctl("idle", 6'b1_0_0_0_00);
    // load r8 in EX, ID reads Rs=8
    @(negedge clk);
    EX_MemRd = 1; EX_Rt = 8; ID_Rs = 8; ID_UsesRs = 1;
    #1;
    ctl("loaduse_rs", 6'b0_0_1_1_01);
    @(negedge clk);
    EX_MemRd = 0;
    #1;
    ctl("loaduse_clear", 6'b1_0_0_0_00);
    chk("stallcnt_1", StallCount, 1);
    // load to $0 never stalls
    @(negedge clk);
    EX_MemRd = 1; EX_Rt = 0; ID_Rs = 0; ID_UsesRs = 1;
    #1;
    ctl("load_r0", 6'b1_0_0_0_00);
    // Rt matches but is not read
    @(negedge clk);
    EX_Rt = 9; ID_Rt = 9; ID_Rs = 3; ID_UsesRt = 0;
    #1;
    ctl("rt_unused", 6'b1_0_0_0_00);
    @(negedge clk);
    ID_UsesRt = 1;
    #1;
    ctl("loaduse_rt", 6'b0_0_1_1_01);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("stallcnt_2", StallCount, 2);
    // mult/div issue with ID_MDUse held high
    @(negedge clk);
    EX_MDStart = 1; ID_MDUse = 1;
    #1;
    ctl("md_issue", 6'b1_0_0_0_00);
    chk("md_issue_busy", MD_Busy, 0);
    @(negedge clk);
    EX_MDStart = 0; ID_Jump = 1;
    #1;
    ctl("md_wait_jump", 6'b0_0_1_1_10);
    chk("md_busy_c1", MD_Busy, 1);
    @(negedge clk);
    ID_Jump = 0;
    for (int i = 2; i <= 8; i++) begin
      #1;
      ctl($sformatf("md_wait_c%0d", i), 6'b0_0_1_1_10);
      chk($sformatf("md_busy_c%0d", i), MD_Busy, 1);
      @(negedge clk);
    end
    #1;
    chk("md_busy_done", MD_Busy, 0);
    ctl("md_release", 6'b1_0_0_0_00);
    chk("stallcnt_10", StallCount, 10);
    chk("flushcnt_0", FlushCount, 0);
    @(negedge clk);
    ID_MDUse = 0; ID_Jump = 1;
    #1;
    ctl("jump", 6'b1_1_0_0_00);
    @(negedge clk);
    ID_Jump = 0;
    #1;
    chk("flushcnt_1", FlushCount, 1);
    // branch beats load-use and jump
    @(negedge clk);
    EX_BranchTaken = 1; EX_MemRd = 1; EX_Rt = 8; ID_Rs = 8; ID_UsesRs = 1; ID_Jump = 1;
    #1;
    ctl("branch_prio", 6'b1_1_0_1_11);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("flushcnt_2", FlushCount, 2);
    chk("stallcnt_hold", StallCount, 10);
    // branch does not cancel a mult/div; reset mid-busy does
    @(negedge clk);
    EX_MDStart = 1;
    @(negedge clk);
    EX_MDStart = 0; EX_BranchTaken = 1;
    @(negedge clk);
    EX_BranchTaken = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("busy_after_branch", MD_Busy, 1);
    reset = 1;
    #1;
    chk("midreset_busy", MD_Busy, 0);
    chk("midreset_stallcnt", StallCount, 0);
    chk("midreset_flushcnt", FlushCount, 0);
    ctl("midreset_ctl", 6'b0_1_0_1_00);
    @(negedge clk);
    reset = 0; ID_MDUse = 1;
    #1;
    ctl("post_reset_md", 6'b1_0_0_0_00);
    chk("post_reset_busy", MD_Busy, 0);
    @(negedge clk);
    idle_inputs();
    // statistics counter wrap at 4 bits
    EX_MemRd = 1; EX_Rt = 4; ID_Rs = 4; ID_UsesRs = 1;
    repeat (15) @(negedge clk);
    #1;
    chk("stallcnt_15", StallCount, 15);
    @(negedge clk);
    #1;
    chk("stallcnt_wrap", StallCount, 0);
    chk("flushcnt_wrap_region", FlushCount, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
